// File: rtl/dmem_ctrl_if.sv
// Bundle of the memory-stage request/response signals and the backing-SRAM
// port of the data-memory controller. The controller takes the slave view;
// the surrounding pipeline and SRAM take the master view.
interface dmem_ctrl_if;
  logic        req_en;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        stall;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output req_en, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
    input  stall, rd_data, rd_valid, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_en, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
    output stall, rd_data, rd_valid, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller with a small store buffer. Stores retire into the
// buffer immediately and drain to the SRAM in order; loads are forwarded
// from the youngest matching buffered store or fetched from the SRAM, with
// load misses taking priority over draining between writes.
module dmem_ctrl #(
  parameter int SB_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  dmem_ctrl_if.slave bus
);

  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t state, state_next;

  logic [15:0]      sb_addr [SB_DEPTH];
  logic [15:0]      sb_data [SB_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, count_next;

  logic             fwd_hit;
  logic [15:0]      fwd_data;
  logic [PTR_W-1:0] fwd_idx;

  logic is_store, is_load, load_miss, sb_full;
  logic rd_done, push, pop, load_accept;

  // Scan valid entries oldest to youngest so the youngest matching store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (sb_addr[fwd_idx] == bus.req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[fwd_idx];
      end
    end
  end

  assign is_store    = bus.req_en & bus.req_we;
  assign is_load     = bus.req_en & ~bus.req_we;
  assign load_miss   = is_load & ~fwd_hit;
  assign sb_full     = (count == CNT_W'(SB_DEPTH));
  assign rd_done     = (state == RD) & bus.mem_ack;
  assign pop         = (state == WR) & bus.mem_ack;
  assign push        = is_store & ~sb_full;
  assign load_accept = is_load & (fwd_hit | rd_done);
  assign bus.stall   = (is_store & sb_full) | (load_miss & ~rd_done);

  // Occupancy after this cycle; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Next-state selection and SRAM port drive; a started write always finishes.
  always_comb begin
    state_next    = state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (load_miss)
          state_next = RD;
        else if (count != '0)
          state_next = WR;
      end
      WR: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = sb_addr[head];
        bus.mem_wdata = sb_data[head];
        if (bus.mem_ack) begin
          if (load_miss)
            state_next = RD;
          else if (count_next != '0)
            state_next = WR;
          else
            state_next = IDLE;
        end
      end
      RD: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = bus.req_addr;
        if (bus.mem_ack)
          state_next = (count_next != '0) ? WR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Store-buffer pointers and occupancy; reset simply empties the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + PTR_W'(1);
      if (pop)
        head <= head + PTR_W'(1);
      count <= count_next;
    end
  end

  // Store-buffer payload; only entries below the occupancy count are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= bus.req_addr;
      sb_data[tail] <= bus.req_wdata;
    end
  end

  // Registered load result, pulsed for exactly one cycle per accepted load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= load_accept;
      if (load_accept)
        bus.rd_data <= fwd_hit ? fwd_data : bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios followed by random
// traffic, all judged against an architectural memory model (every load
// returns the latest value stored to its address) plus an in-order queue of
// stores not yet written to the SRAM.
module tb_dmem_ctrl;

  localparam int SB_DEPTH = 2;

  logic clk;
  logic reset;

  dmem_ctrl_if dif ();

  dmem_ctrl #(.SB_DEPTH(SB_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] sram [65536];
  logic [15:0] arch [65536];
  logic [31:0] pending [$];

  logic        exp_valid;
  logic [15:0] exp_data;
  logic        prev_hold;
  logic [33:0] prev_bus;
  logic        in_reset;
  int          rd_reads;

  bit ack_block;
  int lat_lo, lat_hi, target, wait_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] initWord(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic bit pendingHas(input logic [15:0] a);
    foreach (pending[i])
      if (pending[i][31:16] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one request and hold it until the controller stops stalling.
  task automatic applyStimulus(input logic we, input logic [15:0] addr,
                               input logic [15:0] data, output int waits);
    dif.req_en    = 1'b1;
    dif.req_we    = we;
    dif.req_addr  = addr;
    dif.req_wdata = data;
    waits = 0;
    while (waits <= 300) begin
      @(negedge clk);
      if (!dif.stall) break;
      waits++;
    end
    if (waits > 300) checkOutput("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    dif.req_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((pending.size() != 0 || dif.mem_req) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) checkOutput("drain_timeout", 1, 0);
  endtask

  // SRAM responder: acknowledges after a programmable number of wait cycles.
  initial begin
    dif.mem_ack   = 1'b0;
    dif.mem_rdata = '0;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (dif.mem_req && !ack_block) begin
        if (wait_cnt >= target) begin
          dif.mem_ack   = 1'b1;
          dif.mem_rdata = dif.mem_we ? 16'h0000 : sram[dif.mem_addr];
          wait_cnt = 0;
          target   = $urandom_range(lat_hi, lat_lo);
        end else begin
          dif.mem_ack   = 1'b0;
          dif.mem_rdata = 16'($urandom);
          wait_cnt++;
        end
      end else begin
        dif.mem_ack   = 1'b0;
        dif.mem_rdata = 16'($urandom);
        if (!dif.mem_req) wait_cnt = 0;
      end
    end
  end

  // Monitor: at each falling edge, check the results of the previous rising
  // edge, then predict what the coming rising edge will do.
  initial begin
    exp_valid = 1'b0;
    exp_data  = '0;
    prev_hold = 1'b0;
    prev_bus  = '0;
    in_reset  = 1'b0;
    rd_reads  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        checkOutput("rst_mem_req", dif.mem_req, 0);
        checkOutput("rst_mem_we", dif.mem_we, 0);
        checkOutput("rst_rd_valid", dif.rd_valid, 0);
        checkOutput("rst_rd_data", dif.rd_data, 0);
        if (!in_reset) begin
          pending.delete();
          arch = sram;
        end
        in_reset  = 1'b1;
        exp_valid = 1'b0;
        prev_hold = 1'b0;
      end else begin
        in_reset = 1'b0;
        checkOutput("rd_valid", dif.rd_valid, exp_valid);
        if (exp_valid) checkOutput("rd_data", dif.rd_data, exp_data);

        if (dif.req_en && dif.req_we)
          checkOutput("store_stall", dif.stall, (pending.size() == SB_DEPTH));
        if (dif.req_en && !dif.req_we && pendingHas(dif.req_addr))
          checkOutput("hit_stall", dif.stall, 0);
        if (dif.req_en && !dif.req_we && !pendingHas(dif.req_addr) && !dif.mem_ack)
          checkOutput("miss_stall", dif.stall, 1);

        if (dif.mem_req && !dif.mem_we)
          checkOutput("rd_bus", {dif.req_en, dif.req_we, dif.mem_addr, dif.mem_wdata},
                      {2'b10, dif.req_addr, 16'h0000});

        if (prev_hold)
          checkOutput("mem_hold", {dif.mem_req, dif.mem_we, dif.mem_addr, dif.mem_wdata},
                      prev_bus);
        prev_hold = dif.mem_req && !dif.mem_ack;
        prev_bus  = {dif.mem_req, dif.mem_we, dif.mem_addr, dif.mem_wdata};

        exp_valid = 1'b0;
        if (dif.mem_req && dif.mem_we && dif.mem_ack) begin
          if (pending.size() == 0) begin
            checkOutput("spurious_write", 1, 0);
          end else begin
            checkOutput("write_order", {dif.mem_addr, dif.mem_wdata}, pending[0]);
            void'(pending.pop_front());
          end
          sram[dif.mem_addr] = dif.mem_wdata;
        end
        if (dif.mem_req && !dif.mem_we && dif.mem_ack) rd_reads++;
        if (dif.req_en && !dif.stall) begin
          if (dif.req_we) begin
            pending.push_back({dif.req_addr, dif.req_wdata});
            arch[dif.req_addr] = dif.req_wdata;
          end else begin
            exp_valid = 1'b1;
            exp_data  = arch[dif.req_addr];
          end
        end
      end
    end
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    int w;
    int reads0;
    logic        r_we;
    logic [15:0] r_addr;

    for (int i = 0; i < 65536; i++) begin
      sram[i] = initWord(16'(i));
      arch[i] = initWord(16'(i));
    end
    dif.req_en    = 1'b0;
    dif.req_we    = 1'b0;
    dif.req_addr  = '0;
    dif.req_wdata = '0;
    reset     = 1'b0;
    ack_block = 1'b0;
    lat_lo    = 0;
    lat_hi    = 2;
    target    = 1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_mem_req", dif.mem_req, 0);
    checkOutput("reset_rd_valid", dif.rd_valid, 0);
    reset = 1'b1;

    $display("[TB] store then forwarded load");
    reads0 = rd_reads;
    applyStimulus(1'b1, 16'h0010, 16'hBEEF, w);
    checkOutput("first_store_wait", w, 0);
    applyStimulus(1'b0, 16'h0010, 16'h0000, w);
    checkOutput("fwd_wait", w, 0);
    checkOutput("fwd_rd_valid", dif.rd_valid, 1);
    checkOutput("fwd_rd_data", dif.rd_data, 16'hBEEF);
    checkOutput("fwd_no_read", rd_reads - reads0, 0);

    $display("[TB] load miss with three-cycle stall");
    waitDrain();
    sram[16'h0040] = 16'h1234;
    arch[16'h0040] = 16'h1234;
    lat_lo = 2;
    lat_hi = 2;
    target = 2;
    applyStimulus(1'b0, 16'h0040, 16'h0000, w);
    checkOutput("miss_stall_cycles", w, 3);
    checkOutput("miss_rd_valid", dif.rd_valid, 1);
    checkOutput("miss_rd_data", dif.rd_data, 16'h1234);

    $display("[TB] full buffer stalls third store");
    waitDrain();
    ack_block = 1'b1;
    lat_lo = 0;
    lat_hi = 0;
    target = 0;
    applyStimulus(1'b1, 16'h0070, 16'h0A0A, w);
    checkOutput("full_store1_wait", w, 0);
    applyStimulus(1'b1, 16'h0071, 16'h0B0B, w);
    checkOutput("full_store2_wait", w, 0);
    fork
      begin
        repeat (5) @(posedge clk);
        #3;
        ack_block = 1'b0;
      end
    join_none
    applyStimulus(1'b1, 16'h0072, 16'h0C0C, w);
    checkOutput("full_store3_stalled", (w >= 5), 1);
    waitDrain();
    checkOutput("full_sram_70", sram[16'h0070], 16'h0A0A);
    checkOutput("full_sram_72", sram[16'h0072], 16'h0C0C);

    $display("[TB] youngest matching store forwards");
    ack_block = 1'b1;
    applyStimulus(1'b1, 16'h0020, 16'h1111, w);
    applyStimulus(1'b1, 16'h0020, 16'h2222, w);
    applyStimulus(1'b0, 16'h0020, 16'h0000, w);
    checkOutput("young_wait", w, 0);
    checkOutput("young_rd_data", dif.rd_data, 16'h2222);
    ack_block = 1'b0;

    $display("[TB] load miss during a write");
    waitDrain();
    lat_lo = 3;
    lat_hi = 3;
    target = 3;
    applyStimulus(1'b1, 16'h0030, 16'hAAAA, w);
    idle(1);
    checkOutput("in_write", {dif.mem_req, dif.mem_we}, 2'b11);
    applyStimulus(1'b0, 16'h0050, 16'h0000, w);
    checkOutput("write_before_read", sram[16'h0030], 16'hAAAA);
    checkOutput("wr_miss_rd_data", dif.rd_data, initWord(16'h0050));

    $display("[TB] reset during write discards buffer");
    waitDrain();
    ack_block = 1'b1;
    lat_lo = 0;
    lat_hi = 3;
    target = 1;
    applyStimulus(1'b1, 16'h0060, 16'h7777, w);
    applyStimulus(1'b1, 16'h0061, 16'h8888, w);
    checkOutput("busy_before_reset", {dif.mem_req, dif.mem_we}, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_mem_req", dif.mem_req, 0);
    checkOutput("async_mem_we", dif.mem_we, 0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    ack_block = 1'b0;
    reads0 = rd_reads;
    applyStimulus(1'b0, 16'h0060, 16'h0000, w);
    checkOutput("post_reset_miss", (w > 0), 1);
    checkOutput("post_reset_read", rd_reads - reads0, 1);
    checkOutput("post_reset_data", dif.rd_data, initWord(16'h0060));

    $display("[TB] random traffic");
    lat_lo = 0;
    lat_hi = 3;
    for (int n = 0; n < 400; n++) begin
      r_we   = 1'($urandom_range(1, 0));
      r_addr = ($urandom_range(7, 0) == 0) ? 16'($urandom)
                                           : 16'h0100 + 16'($urandom_range(5, 0));
      applyStimulus(r_we, r_addr, 16'($urandom), w);
      if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
    end
    waitDrain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter SB_DEPTH, default 2, meaning store-buffer entry count (power of two, 2..8).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; clk is the only clock.
REQ-004 req_en  input  1  memory-stage request valid.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  16  word address.
REQ-007 req_wdata  input  16  store data.
REQ-008 stall  output  1  combinational; requester holds req_* stable while high.
REQ-009 rd_data  output  16  registered load result.
REQ-010 rd_valid  output  1  registered one-cycle pulse marking rd_data.
REQ-011 mem_req / mem_we  output  1 / 1  backing-SRAM transaction valid / write.
REQ-012 mem_addr / mem_wdata  output  16 / 16  SRAM address / write data.
REQ-013 mem_rdata  input  16  SRAM read data, valid when mem_ack=1.
REQ-014 mem_ack  input  1  SRAM completion; a transaction completes on an edge with mem_req=1 and mem_ack=1.

Function
REQ-015 Request accepted on a rising edge with req_en=1 and stall=0.
REQ-016 Store accepted: pushed to store-buffer tail {addr, data}; no SRAM access that cycle.
REQ-017 stall=1 for a store while buffer full, even in a pop cycle (no push-through).
REQ-018 Load hit = req_addr equals any valid buffer entry, full 16-bit compare; youngest match wins.
REQ-019 Load hit: stall=0; next cycle rd_data=forwarded data, rd_valid=1 (1-cycle latency).
REQ-020 Load miss: stall=1 until FSM in RD and mem_ack=1; that edge accepts the load, rd_data<=mem_rdata, rd_valid=1 next cycle.
REQ-021 Entry being popped in the same cycle remains forwardable that cycle.
REQ-022 FSM states IDLE, WR, RD; mem_req=1 exactly in WR and RD; mem_we=1 only in WR.
REQ-023 WR: mem_addr/mem_wdata = buffer head; RD: mem_addr = req_addr, mem_wdata=0.
REQ-024 IDLE -> RD if load miss present; else IDLE -> WR if buffer non-empty; else stay.
REQ-025 WR on mem_ack: pop head; -> RD if load miss present, else WR if entries remain, else IDLE.
REQ-026 RD on mem_ack: -> WR if buffer non-empty, else IDLE.
REQ-027 No mem_ack: WR/RD hold state and all mem_* outputs stable.
REQ-028 Load miss has priority over draining but never aborts an in-flight write.
REQ-029 Buffer pointers wrap modulo SB_DEPTH; count range 0..SB_DEPTH; push and pop in one cycle leave count unchanged.
REQ-030 Stores reach SRAM in program order; loads may complete before older non-matching stores.
REQ-031 rd_valid=0 in every cycle not following an accepted load.

Reset
REQ-032 reset=0 immediately forces: FSM IDLE, buffer empty, mem_req=0, mem_we=0, rd_valid=0, rd_data=0.
REQ-033 Reset mid-transaction discards buffered stores and in-flight load; mem_req drops without waiting for mem_ack.
REQ-034 After deassertion, first request accepted on the first rising edge with reset=1.

Verification
REQ-035 Store 0x0010<-0xBEEF, then load 0x0010 next cycle -> stall=0, rd_data=0xBEEF, rd_valid=1 one cycle later, no mem read.
REQ-036 Load miss 0x0040, mem_ack after 3 cycles with mem_rdata=0x1234 -> stall high 3 cycles, rd_data=0x1234 the cycle after ack.
REQ-037 SB_DEPTH=2, SRAM ack held low, three stores -> third stalls until first write acked; SRAM sees writes in issue order.
REQ-038 Stores 0x0020<-0x1111, 0x0020<-0x2222, load 0x0020 -> rd_data=0x2222.
REQ-039 Load miss arriving during WR -> write completes first, then RD; load result correct.
REQ-040 reset=0 asserted during WR with 2 entries -> mem_req=0 without a clock edge, buffer empty; post-reset load to that address issues SRAM read.
